mem_subword_responder: RTL and testbench

- Memory-side responder for the multicycle core's load/store port, placed between the datapath (address, write enable, store data, size code) and a word-wide synchronous RAM.
- Serves word reads and writes directly.
- Implements byte and halfword stores as read-modify-write.
- Returns sub-word loads aligned to bit 0 and zero-extended.
- Holds busy until a one-cycle response pulse.

---
 rtl/mem_subword_responder_pkg.sv | 49 ++++
 rtl/subword_lane_align.sv | 22 ++
 rtl/mem_subword_responder.sv | 140 ++++++++++++++
 tb/tb_mem_subword_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_subword_responder_pkg.sv
// mem_resp_pkg: shared types and helpers for the sub-word memory responder.
// The size encoding matches the datapath's store-size mux.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_e;

    // Merge store data into the word read back from RAM; untouched lanes keep
    // their old contents. Word and reserved sizes replace the whole word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input size_e       size,
                                               input logic [1:0]  off);
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{off, 3'b000} +: 8] = new_word[7:0];
            SZ_HALF: begin
                if (off[1]) merged[31:16] = new_word[15:0];
                else        merged[15:0]  = new_word[15:0];
            end
            default: merged = new_word;
        endcase
        return merged;
    endfunction

    // Misaligned halfword/word accesses and the reserved size are errors.
    function automatic logic align_err(input size_e size, input logic [1:0] off);
        case (size)
            SZ_WORD: return off != 2'b00;
            SZ_HALF: return off[0];
            SZ_RSVD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/subword_lane_align.sv
// subword_lane_align: picks the addressed byte/halfword lane out of a RAM word,
// moves it to bit 0 and zero-extends it. Word size passes the word through.
module subword_lane_align
    import mem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  size_e       size,
    input  logic [1:0]  off,
    output logic [31:0] lane_data
);

    // Lane select and zero-extension
    always_comb begin
        lane_data = word;
        case (size)
            SZ_BYTE: lane_data = {24'b0, word[{off, 3'b000} +: 8]};
            SZ_HALF: lane_data = off[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
            default: lane_data = word;
        endcase
    end

endmodule

// File: rtl/mem_subword_responder.sv
// mem_subword_responder: load/store responder between the core's memory port
// and a word-wide synchronous RAM. Word accesses go straight through, byte and
// halfword stores are read-modify-write, sub-word loads come back zero-extended.
// Optional: define MEMRESP_ALIGN_CHECK_EN to flag misaligned or reserved-size
// requests on resp_err (no RAM access) instead of ignoring the low address bits.
module mem_subword_responder
    import mem_resp_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int WORDS  = 256,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_wr,
    input  logic [1:0]    req_size,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          busy,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    state_e      state;
    logic [1:0]  wait_cnt;
    logic        lat_wr;
    size_e       lat_size;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;
    logic [31:0] load_data;
    logic        req_bad;
    logic        req_word;
    logic        unused_addr_bits;

    // Byte address bits above the RAM depth do not select anything.
    assign unused_addr_bits = ^req_addr[31:AW+2];

    // Reserved size behaves as a word whenever it is not flagged as an error.
    assign req_word = (size_e'(req_size) == SZ_WORD) || (size_e'(req_size) == SZ_RSVD);

`ifdef MEMRESP_ALIGN_CHECK_EN
    assign req_bad = align_err(size_e'(req_size), req_addr[1:0]);
`else
    assign req_bad = 1'b0;
`endif

    subword_lane_align u_align (
        .word      (ram_rdata),
        .size      (lat_size),
        .off       (lat_off),
        .lane_data (load_data)
    );

    // Request FSM; every port output is a register updated on the transition.
    // WAIT spans the RAM read latency so ram_rdata is sampled as it turns valid.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            lat_wr     <= 1'b0;
            lat_size   <= SZ_WORD;
            lat_off    <= '0;
            lat_wdata  <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ram_addr   <= '0;
            ram_wr     <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            ram_wr     <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_wr    <= req_wr;
                        lat_size  <= size_e'(req_size);
                        lat_off   <= req_addr[1:0];
                        lat_wdata <= req_wdata;
                        busy      <= 1'b1;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_DONE;
                        end else if (req_wr && req_word) begin
                            ram_addr  <= req_addr[AW+1:2];
                            ram_wdata <= req_wdata;
                            ram_wr    <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            ram_addr <= req_addr[AW+1:2];
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    wait_cnt <= 2'(RD_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        if (lat_wr) begin
                            ram_wdata <= lane_merge(ram_rdata, lat_wdata, lat_size, lat_off);
                            ram_wr    <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            resp_rdata <= load_data;
                            resp_valid <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_WR: begin
                    resp_valid <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    busy       <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    ram_addr   <= '0;
                    ram_wdata  <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_subword_responder.sv
// tb_mem_subword_responder: directed plus random load/store checks of
// mem_subword_responder against a byte-lane reference memory.
module tb_mem_subword_responder;

    localparam int RD_LAT = 1;
    localparam int WORDS  = 256;
    localparam int AW     = $clog2(WORDS);

    logic          Clk;
    logic          reset;
    logic          req_valid;
    logic          req_wr;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          busy;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] rpipe   [3];
    logic        pl_en;
    logic [AW-1:0] pl_idx;
    logic [31:0] pl_val;

    mem_subword_responder #(.RD_LAT(RD_LAT), .WORDS(WORDS)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_wr     (ram_wr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous RAM: data for an address appears RD_LAT cycles later.
    always @(posedge Clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        else if (pl_en) mem[pl_idx] <= pl_val;
        rpipe[0] <= mem[ram_addr];
        for (int k = 1; k < 3; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge Clk);
        pl_en  = 1'b1;
        pl_idx = AW'(idx);
        pl_val = val;
        @(negedge Clk);
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One request through to completion, checked against the byte-lane model.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got);
        int idx, n, start, lat, nwr, exp_lat;
        logic err;
        logic [31:0] exp_rd, w;
        idx   = int'(addr[9:2]);
        n     = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
        start = (size == 2'b01) ? int'(addr[1:0]) :
                (size == 2'b10) ? (int'(addr[1:0]) & 2) : 0;
        err = 1'b0;
`ifdef MEMRESP_ALIGN_CHECK_EN
        err = (size == 2'b11) || (size == 2'b10 && addr[0]) ||
              (size == 2'b00 && addr[1:0] != 2'b00);
`endif
        exp_rd = 32'h0;
        w = ref_mem[idx];
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (wr)
                    w = (w & ~(32'hFF << (8*(start+i)))) |
                        (((wdata >> (8*i)) & 32'hFF) << (8*(start+i)));
                else
                    exp_rd = exp_rd | (((w >> (8*(start+i))) & 32'hFF) << (8*i));
            end
        end
        if (err)         exp_lat = 1;
        else if (!wr)    exp_lat = RD_LAT + 2;
        else if (n == 4) exp_lat = 2;
        else             exp_lat = RD_LAT + 3;

        @(negedge Clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge Clk);
        req_valid = 1'b0;
        lat = 1;
        nwr = 0;
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        while (!resp_valid && lat < 20) begin
            if (ram_wr) nwr++;
            @(negedge Clk);
            lat++;
        end
        if (ram_wr) nwr++;
        got = resp_rdata;
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/err"}, 32'(resp_err), 32'(err));
        if (!wr || err) chk({tag, "/rdata"}, resp_rdata, exp_rd);
        chk({tag, "/ram_wr_count"}, 32'(nwr), (wr && !err) ? 32'd1 : 32'd0);
        @(negedge Clk);
        chk({tag, "/idle"}, {30'b0, busy, resp_valid}, 32'd0);
        if (wr && !err) begin
            ref_mem[idx] = w;
            chk({tag, "/ram"}, mem[idx], w);
        end
    endtask

    // Directed and random sequence
    initial begin
        logic [31:0] got;
        logic [6:0]  obs_wr, obs_rv, obs_busy;
        int          cnt;
        reset = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
        req_addr = '0; req_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        repeat (3) @(negedge Clk);
        chk("reset/ctl", {28'b0, busy, resp_valid, resp_err, ram_wr}, 32'd0);
        chk("reset/rdata", resp_rdata, 32'd0);
        chk("reset/addr", 32'(ram_addr), 32'd0);
        chk("reset/wdata", ram_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) preload(i, $urandom);

        preload(4, 32'h11223344);
        do_req("byte_ld", 1'b0, 2'b01, 32'h12, 32'h0, got);
        chk("byte_ld/value", got, 32'h00000022);
        do_req("byte_st", 1'b1, 2'b01, 32'h11, 32'hAB, got);
        chk("byte_st/value", mem[4], 32'h1122AB44);

        preload(3, 32'hFFFFFFFF);
        do_req("half_st", 1'b1, 2'b10, 32'h0E, 32'hBEEF, got);
        chk("half_st/value", mem[3], 32'hBEEFFFFF);
        do_req("half_ld", 1'b0, 2'b10, 32'h0E, 32'h0, got);
        chk("half_ld/value", got, 32'h0000BEEF);

        // Word store with a second request held while busy.
        @(negedge Clk);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00;
        req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        obs_wr = '0; obs_rv = '0; obs_busy = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            obs_wr[c] = ram_wr; obs_rv[c] = resp_valid; obs_busy[c] = busy;
            if (c == 1) begin req_addr = 32'h24; req_wdata = 32'h12345678; end
            if (c == 4) req_valid = 1'b0;
        end
        ref_mem[8] = 32'hDEADBEEF;
        ref_mem[9] = 32'h12345678;
        chk("b2b/ram_wr", 32'(obs_wr), 32'b0010010);
        chk("b2b/resp_valid", 32'(obs_rv), 32'b0100100);
        chk("b2b/busy", 32'(obs_busy), 32'b0110110);
        chk("b2b/ram8", mem[8], 32'hDEADBEEF);
        chk("b2b/ram9", mem[9], 32'h12345678);

        // Reset during the read wait of a byte store abandons it.
        preload(5, 32'h55667788);
        @(negedge Clk);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b01;
        req_addr = 32'h16; req_wdata = 32'h99;
        cnt = 0;
        @(negedge Clk);
        req_valid = 1'b0;
        if (ram_wr || resp_valid) cnt++;
        @(negedge Clk);
        if (ram_wr || resp_valid) cnt++;
        reset = 1'b1;
        @(negedge Clk);
        chk("rst_mid/ctl", {28'b0, busy, resp_valid, resp_err, ram_wr}, 32'd0);
        chk("rst_mid/addr", 32'(ram_addr), 32'd0);
        reset = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (ram_wr || resp_valid) cnt++;
        end
        chk("rst_mid/activity", 32'(cnt), 32'd0);
        chk("rst_mid/ram", mem[5], 32'h55667788);

        // Misaligned word store: error when checking, else lane 0 write.
        preload(0, 32'h0);
        do_req("misalign_st", 1'b1, 2'b00, 32'h02, 32'hCAFEF00D, got);
`ifdef MEMRESP_ALIGN_CHECK_EN
        chk("misalign_st/ram", mem[0], 32'h0);
`else
        chk("misalign_st/ram", mem[0], 32'hCAFEF00D);
`endif

        for (int i = 0; i < 40; i++) begin
            do_req($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
